// File: rtl/jk_pkg.sv
// Shared types and constants for the JK flag arbiter: command encoding,
// counter width and the JK next-state rule.
package jk_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        CLR  = 2'b01,
        SET  = 2'b10,
        TOG  = 2'b11
    } jk_cmd_e;

    // The command encoding is {j, k}.
    function automatic logic jk_next(input jk_cmd_e cmd, input logic q);
        logic j;
        logic k;
        j = cmd[1];
        k = cmd[0];
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_flag_arbiter_rr_arb.sv
// Round-robin arbiter: the search starts at ptr and wraps upward; ptr moves
// just past the winner whenever the grant is taken.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   ptr
);

    localparam int SW = PW + 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;
    logic [SW-1:0] sum;
    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        win   = ptr_q;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            cand = sum[PW-1:0];
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                win       = cand;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = ({1'b0, win} == SW'(NREQ - 1)) ? '0 : win + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/jk_flag_arbiter.sv
// Shared JK flag bank updated by one round-robin-selected requester per cycle,
// with a synchronous bank clear and a saturating count of applied commands.
module jk_flag_arbiter
    import jk_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IW    = $clog2(NFLAG),
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_j,
    input  logic [NREQ-1:0]    req_k,
    input  logic [NREQ*IW-1:0] req_idx,
    input  logic               clr_all,
    output logic [NREQ-1:0]    grant,
    output logic [NFLAG-1:0]   flags,
    output logic [CNT_W-1:0]   upd_cnt,
    output logic [PW-1:0]      arb_ptr
);

    // Handshake: requester r's command is taken at posedge clk exactly when
    // req_valid[r] and grant[r] are both high; grant is the same-cycle ready.
    logic [NREQ-1:0]  req_eff;
    logic             acc;
    logic             sel_j;
    logic             sel_k;
    logic [IW-1:0]    sel_idx;
    jk_cmd_e          cmd;
    logic [NFLAG-1:0] flags_q;
    logic [NFLAG-1:0] flags_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Masking the requests keeps grant low during clear and reset.
    assign req_eff = req_valid & {NREQ{rstn & ~clr_all}};
    assign acc     = |grant;

    rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_eff),
        .advance (acc),
        .gnt     (grant),
        .ptr     (arb_ptr)
    );

    always_comb begin
        sel_j   = 1'b0;
        sel_k   = 1'b0;
        sel_idx = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (grant[r]) begin
                sel_j   = req_j[r];
                sel_k   = req_k[r];
                sel_idx = req_idx[r*IW +: IW];
            end
        end
    end

    assign cmd = jk_cmd_e'({sel_j, sel_k});

    always_comb begin
        flags_d = flags_q;
        cnt_d   = cnt_q;
        if (clr_all) begin
            flags_d = '0;
        end else if (acc) begin
            // Out-of-range indices are consumed without touching the bank.
            if (int'(sel_idx) < NFLAG) begin
                flags_d[sel_idx] = jk_next(cmd, flags_q[sel_idx]);
            end
            if (cmd != HOLD && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flags   = flags_q;
    assign upd_cnt = cnt_q;

endmodule

// File: tb/tb_jk_flag_arbiter.sv
// Bench for jk_flag_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_jk_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IW    = 3;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_j = '0;
    logic [NREQ-1:0]    req_k = '0;
    logic [NREQ*IW-1:0] req_idx = '0;
    logic               clr_all = 1'b0;
    logic [NREQ-1:0]    grant;
    logic [NFLAG-1:0]   flags;
    logic [7:0]         upd_cnt;
    logic [1:0]         arb_ptr;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [NFLAG-1:0] m_flags = '0;
    int               m_ptr   = 0;
    int               m_cnt   = 0;

    jk_flag_arbiter #(
        .NREQ  (NREQ),
        .NFLAG (NFLAG),
        .IW    (IW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_j     (req_j),
        .req_k     (req_k),
        .req_idx   (req_idx),
        .clr_all   (clr_all),
        .grant     (grant),
        .flags     (flags),
        .upd_cnt   (upd_cnt),
        .arb_ptr   (arb_ptr)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic int m_winner(input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_grant();
        int w;
        if (!rstn || clr_all) return '0;
        w = m_winner(m_ptr);
        if (w < 0) return '0;
        return NREQ'(1) << w;
    endfunction

    function automatic logic [NFLAG-1:0] m_next_flags();
        logic [NFLAG-1:0] f;
        int w;
        int idx;
        f = m_flags;
        if (clr_all) return '0;
        w = m_winner(m_ptr);
        if (w < 0) return f;
        idx = int'(req_idx[w*IW +: IW]);
        if (idx >= NFLAG) return f;
        case ({req_j[w], req_k[w]})
            2'b10:   f[idx] = 1'b1;
            2'b01:   f[idx] = 1'b0;
            2'b11:   f[idx] = ~f[idx];
            default: f[idx] = f[idx];
        endcase
        return f;
    endfunction

    function automatic int m_next_ptr();
        int w;
        if (clr_all) return m_ptr;
        w = m_winner(m_ptr);
        if (w < 0) return m_ptr;
        return (w + 1) % NREQ;
    endfunction

    function automatic int m_next_cnt();
        int w;
        if (clr_all) return m_cnt;
        w = m_winner(m_ptr);
        if (w < 0) return m_cnt;
        if (!(req_j[w] | req_k[w])) return m_cnt;
        return (m_cnt >= 255) ? 255 : m_cnt + 1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_flags <= '0;
            m_ptr   <= 0;
            m_cnt   <= 0;
        end else begin
            m_flags <= m_next_flags();
            m_ptr   <= m_next_ptr();
            m_cnt   <= m_next_cnt();
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_grant", 32'(grant), 32'(m_grant()));
            chk("model_flags", 32'(flags), 32'(m_flags));
            chk("model_cnt", 32'(upd_cnt), 32'(m_cnt));
            chk("model_ptr", 32'(arb_ptr), 32'(m_ptr));
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_j     = '0;
        req_k     = '0;
        req_idx   = '0;
        clr_all   = 1'b0;
    endtask

    task automatic cmd(input int r, input bit j, input bit k, input int idx);
        req_valid[r]       = 1'b1;
        req_j[r]           = j;
        req_k[r]           = k;
        req_idx[r*IW +: IW] = IW'(idx);
    endtask

    task automatic one_cmd(input int r, input bit j, input bit k, input int idx);
        idle();
        cmd(r, j, k, idx);
        tick();
    endtask

    initial begin
        check_en = 1'b1;
        // Reset with all requesters valid: nothing is granted or applied.
        for (int r = 0; r < NREQ; r++) cmd(r, 1'b1, 1'b0, r);
        #2;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_flags", 32'(flags), 32'h0);
        chk("reset_cnt", 32'(upd_cnt), 32'h0);
        tick();
        tick();
        idle();
        rstn = 1'b1;

        // Single set command from req0
        cmd(0, 1'b1, 1'b0, 3);
        #1;
        chk("set_grant", 32'(grant), 32'h1);
        tick();
        idle();
        chk("set_flags", 32'(flags), 32'h08);
        chk("set_cnt", 32'(upd_cnt), 32'd1);

        // Two toggles from req2
        cmd(2, 1'b1, 1'b1, 3);
        #1;
        chk("tog_grant", 32'(grant), 32'h4);
        tick();
        chk("tog_flags0", 32'(flags), 32'h00);
        one_cmd(2, 1'b1, 1'b1, 5);
        idle();
        chk("tog_flags1", 32'(flags), 32'h20);
        chk("tog_cnt", 32'(upd_cnt), 32'd3);

        // Hold from req3 brings ptr back to 0 without counting
        one_cmd(3, 1'b0, 1'b0, 5);
        chk("hold_flags", 32'(flags), 32'h20);
        chk("hold_cnt", 32'(upd_cnt), 32'd3);

        // All four continuously valid: strict rotation
        idle();
        for (int r = 0; r < NREQ; r++) cmd(r, 1'b0, 1'b0, 0);
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_grant", 32'(grant), 32'(1 << (c % NREQ)));
            tick();
        end

        // Fill the bank, then clear it with req1 pending
        for (int i = 0; i < NFLAG; i++) one_cmd(0, 1'b1, 1'b0, i);
        chk("fill_flags", 32'(flags), 32'hFF);
        idle();
        clr_all = 1'b1;
        cmd(1, 1'b1, 1'b0, 0);
        #1;
        chk("clr_grant", 32'(grant), 32'h0);
        tick();
        chk("clr_flags", 32'(flags), 32'h00);
        chk("clr_cnt", 32'(upd_cnt), 32'd11);
        chk("clr_ptr", 32'(arb_ptr), 32'd1);
        clr_all = 1'b0;
        cmd(0, 1'b1, 1'b0, 7);
        #1;
        chk("after_clr_grant", 32'(grant), 32'h2);
        tick();
        idle();
        chk("after_clr_flags", 32'(flags), 32'h01);

        // Saturation of the update counter
        for (int i = 0; i < 300; i++) one_cmd(0, 1'b1, 1'b1, 7);
        chk("sat_cnt", 32'(upd_cnt), 32'd255);
        chk("sat_flags", 32'(flags), 32'h01);
        one_cmd(0, 1'b0, 1'b0, 0);
        chk("sat_hold_cnt", 32'(upd_cnt), 32'd255);
        chk("sat_hold_flags", 32'(flags), 32'h01);

        // Build 0x5A with ptr=2, then reset mid-cycle
        idle();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        one_cmd(0, 1'b1, 1'b0, 1);
        one_cmd(0, 1'b1, 1'b0, 3);
        one_cmd(0, 1'b1, 1'b0, 4);
        one_cmd(1, 1'b1, 1'b0, 6);
        idle();
        chk("pre_rst_flags", 32'(flags), 32'h5A);
        chk("pre_rst_ptr", 32'(arb_ptr), 32'd2);
        cmd(3, 1'b1, 1'b0, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_flags", 32'(flags), 32'h0);
        chk("async_rst_cnt", 32'(upd_cnt), 32'h0);
        chk("async_rst_grant", 32'(grant), 32'h0);
        tick();
        rstn = 1'b1;
        idle();
        cmd(1, 1'b0, 1'b0, 0);
        cmd(3, 1'b0, 1'b0, 0);
        #1;
        chk("post_rst_grant", 32'(grant), 32'h2);
        tick();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            req_j     = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            req_k     = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            req_idx   = (NREQ*IW)'($urandom);
            clr_all   = ($urandom_range(0, 19) == 0);
            rstn      = ($urandom_range(0, 99) != 0);
            tick();
        end
        rstn = 1'b1;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
